con_u: RTL and testbench

- Branch condition unit for the single-bus SRC-style CPU datapath.
- Decodes the condition field of the current instruction and evaluates it against the value on the shared datapath bus.
- Latches the result into the one-bit CON flip-flop when strobed by the control unit.
- con_out feeds the control unit, which uses it to decide whether a branch writes the PC.

---
 rtl/con_u.sv | 42 ++++
 tb/tb_con_u.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/con_u.sv
// rtl/con_u.sv - branch condition unit: decodes IR[2:0] against the bus and latches CON
module con_u #(
    parameter int w = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [w-1:0] bus,
    input  logic [w-1:0] IR,
    input  logic         con_in,
    output logic         con_out
);

    logic [2:0] c3;
    logic       cond;
    logic       unused_ir_hi;

    assign c3           = IR[2:0];
    assign unused_ir_hi = ^IR[w-1:3];

    // codes 6 and 7 are reserved and never branch
    always_comb begin
        cond = 1'b0;
        case (c3)
            3'd0:    cond = 1'b0;
            3'd1:    cond = 1'b1;
            3'd2:    cond = (bus == '0);
            3'd3:    cond = (bus != '0);
            3'd4:    cond = ~bus[w-1];
            3'd5:    cond = bus[w-1];
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            con_out <= 1'b0;
        end else if (con_in) begin
            con_out <= cond;
        end
    end

endmodule

// File: tb/tb_con_u.sv
// tb/tb_con_u.sv - self-checking bench for con_u with directed and randomized stimulus
module tb_con_u;

    logic        clk;
    logic        rst;
    logic [31:0] bus;
    logic [31:0] IR;
    logic        con_in;
    logic        con_out;

    int n_checks;
    int n_fail;
    bit model_con;

    con_u #(.w(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .IR      (IR),
        .con_in  (con_in),
        .con_out (con_out)
    );

    always #5 clk = ~clk;

    // Reference: branch condition as a signed-integer comparison
    function automatic bit ref_cond(input int code, input int signed value);
        case (code)
            1:       return 1'b1;
            2:       return value == 0;
            3:       return value != 0;
            4:       return value >= 0;
            5:       return value < 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; con_in = 1'b1; bus = 32'd0; IR = 32'd1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (con_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: con_out=%b expected 0", i, con_out);
            end
        end
        rst = 1'b0; IR = 32'd0;
        tick();
        n_checks++;
        if (con_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_never: con_out=%b expected 0", con_out);
        end
        IR = 32'd1;
        tick();
        n_checks++;
        if (con_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_always: con_out=%b expected 1", con_out);
        end
    endtask

    task automatic test_conditions();
        logic [31:0] bus_vals [3];
        logic [3:0]  exp_bits [3];
        logic        exp;
        bus_vals[0] = 32'h0000_0000; exp_bits[0] = 4'b0101;
        bus_vals[1] = 32'h0000_0001; exp_bits[1] = 4'b0110;
        bus_vals[2] = 32'hFFFF_FFFF; exp_bits[2] = 4'b1010;
        rst = 1'b0; con_in = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus = bus_vals[b];
            for (int c = 2; c <= 5; c++) begin
                IR = c;
                tick();
                exp = exp_bits[b][c-2];
                n_checks++;
                if (con_out !== exp) begin
                    n_fail++;
                    $display("FAIL cond bus=%h c3=%0d: con_out=%b expected %b", bus, c, con_out, exp);
                end
            end
        end
    endtask

    task automatic test_sign_boundary();
        con_in = 1'b1; bus = 32'h8000_0000;
        IR = 32'd5;
        tick();
        n_checks++;
        if (con_out !== 1'b1) begin
            n_fail++;
            $display("FAIL min_neg_lt0: con_out=%b expected 1", con_out);
        end
        IR = 32'd4;
        tick();
        n_checks++;
        if (con_out !== 1'b0) begin
            n_fail++;
            $display("FAIL min_neg_ge0: con_out=%b expected 0", con_out);
        end
    endtask

    task automatic test_hold();
        con_in = 1'b1; IR = 32'd1; bus = 32'd0;
        tick();
        n_checks++;
        if (con_out !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_set: con_out=%b expected 1", con_out);
        end
        con_in = 1'b0; IR = 32'd0;
        for (int i = 0; i < 3; i++) begin
            bus = (i == 1) ? 32'hxxxx_xxxx : 32'hzzzz_zzzz;
            tick();
            n_checks++;
            if (con_out !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_idle[%0d]: con_out=%b expected 1", i, con_out);
            end
        end
        con_in = 1'b1; bus = 32'h0000_0005; IR = 32'd6;
        tick();
        n_checks++;
        if (con_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved6: con_out=%b expected 0", con_out);
        end
        IR = 32'd1;
        tick();
        IR = 32'd7;
        tick();
        n_checks++;
        if (con_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved7: con_out=%b expected 0", con_out);
        end
    endtask

    task automatic test_upper_mask();
        con_in = 1'b1; bus = 32'd0; IR = 32'hFFFF_FFF9;
        tick();
        n_checks++;
        if (con_out !== 1'b1) begin
            n_fail++;
            $display("FAIL upper_mask: con_out=%b expected 1", con_out);
        end
        rst = 1'b1; IR = 32'd1;
        tick();
        n_checks++;
        if (con_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_over_load: con_out=%b expected 0", con_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] picks [5];
        logic [31:0] pick_sel;
        picks[0] = 32'h0000_0000;
        picks[1] = 32'h0000_0001;
        picks[2] = 32'h8000_0000;
        picks[3] = 32'h7FFF_FFFF;
        picks[4] = 32'hFFFF_FFFF;
        model_con = con_out;
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 15) == 0);
            con_in   = $urandom_range(0, 1);
            IR       = $urandom;
            pick_sel = $urandom_range(0, 7);
            bus      = (pick_sel < 5) ? picks[pick_sel] : $urandom;
            if (rst)
                model_con = 1'b0;
            else if (con_in)
                model_con = ref_cond(int'(IR % 8), $signed(bus));
            tick();
            n_checks++;
            if (con_out !== model_con) begin
                n_fail++;
                $display("FAIL random[%0d] rst=%b con_in=%b IR=%h bus=%h: con_out=%b expected %b",
                         i, rst, con_in, IR, bus, con_out, model_con);
            end
        end
        rst = 1'b0; con_in = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; con_in = 1'b0; IR = '0; bus = '0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_conditions();
        test_sign_boundary();
        test_hold();
        test_upper_mask();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
